pic10_fetch: RTL and testbench

- Instruction fetch and program-counter stage of the PIC10 core, directly upstream of pic10_alu.
- Owns the PC, the 2-level hardware call stack and the instruction register, and drives ir_reg_bus into pic10_alu and decode.
- Single-cycle fetch with one-deep pipelining: the instruction being executed sits in IR while the next one is fetched.
- Taken control flow and execute-stage skips flush the prefetched word to NOP.

---
 rtl/pic10_pkg.sv | 24 ++
 rtl/pic10_stack.sv | 35 +++
 rtl/pic10_fetch.sv | 69 ++++++
 tb/tb_pic10_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic10_pkg.sv
// Shared widths, NOP encoding and opcode match constants for the PIC10 fetch stage.
package pic10_pkg;
    localparam int          PC_W    = 9;
    localparam int          INSTR_W = 12;
    localparam logic [11:0] NOP     = 12'h000;

    localparam logic [2:0]  OP_GOTO  = 3'b101;   // ir[11:9]
    localparam logic [3:0]  OP_CALL  = 4'b1001;  // ir[11:8]
    localparam logic [3:0]  OP_RETLW = 4'b1000;  // ir[11:8]

    typedef struct packed {
        logic go;
        logic call;
        logic ret;
    } ctl_dec_t;

    function automatic ctl_dec_t decode_ctl(input logic [INSTR_W-1:0] ir);
        ctl_dec_t d;
        d.go   = (ir[11:9] == OP_GOTO);
        d.call = (ir[11:8] == OP_CALL);
        d.ret  = (ir[11:8] == OP_RETLW);
        return d;
    endfunction
endpackage

// File: rtl/pic10_stack.sv
// Two-level hardware call stack; a push when full drops the oldest entry and sets a sticky overflow.
module pic10_stack import pic10_pkg::*; #(
    parameter int W = PC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         ovf
);
    logic [W-1:0] s0, s1;
    logic [1:0]   depth;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0    <= '0;
            s1    <= '0;
            depth <= 2'd0;
            ovf   <= 1'b0;
        end else if (push) begin
            s1 <= s0;
            s0 <= din;
            if (depth == 2'd2) ovf   <= 1'b1;
            else               depth <= depth + 2'd1;
        end else if (pop) begin
            // s1 is left in place, so an over-deep return chain repeats it
            s0 <= s1;
            if (depth != 2'd0) depth <= depth - 2'd1;
        end
    end

    assign top = s0;
endmodule

// File: rtl/pic10_fetch.sv
// PIC10 fetch stage: PC, call stack and instruction register with flush-to-NOP on taken flow and skips.
module pic10_fetch import pic10_pkg::*; #(
    parameter int                  PC_WIDTH     = PC_W,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 9'h1FF,
    parameter logic [INSTR_W-1:0]  NOP_WORD     = NOP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    output logic [INSTR_W-1:0]  ir_reg_bus,
    output logic                ir_valid,
    input  logic                skip_req,
    input  logic                pcl_we,
    input  logic [7:0]          pcl_data,
    output logic                stack_ovf
);
    logic [PC_WIDTH-1:0] pc, pc_next, stack_top;
    ctl_dec_t            dec;
    logic                pcl_take, go_take, call_take, ret_take;
    logic                taken, flush, push, pop;

    assign dec = decode_ctl(ir_reg_bus);

    // pcl_we outranks decoded flow, so a PCL write never touches the stack
    assign pcl_take  = ir_valid & pcl_we;
    assign go_take   = ir_valid & dec.go   & ~pcl_take;
    assign call_take = ir_valid & dec.call & ~pcl_take;
    assign ret_take  = ir_valid & dec.ret  & ~pcl_take;
    assign taken     = pcl_take | go_take | call_take | ret_take;
    assign flush     = taken | (ir_valid & skip_req);

    assign push = ~stall & call_take;
    assign pop  = ~stall & ret_take;

    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        if (pcl_take)       pc_next = PC_WIDTH'(pcl_data);
        else if (go_take)   pc_next = PC_WIDTH'(ir_reg_bus[8:0]);
        else if (call_take) pc_next = PC_WIDTH'(ir_reg_bus[7:0]);
        else if (ret_take)  pc_next = stack_top;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            ir_reg_bus <= NOP_WORD;
            ir_valid   <= 1'b0;
        end else if (!stall) begin
            pc         <= pc_next;
            ir_reg_bus <= flush ? NOP_WORD : prog_data;
            ir_valid   <= ~flush;
        end
    end

    // pc already points past the CALL, so it is the return address as-is
    pic10_stack #(.W(PC_WIDTH)) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (pc),
        .top  (stack_top),
        .ovf  (stack_ovf)
    );

    assign prog_addr = pc;
endmodule

// File: tb/tb_pic10_fetch.sv
// Self-checking bench for pic10_fetch: directed scenarios plus a randomized run against a behavioural model.
module tb_pic10_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [8:0]  prog_addr;
    logic [11:0] prog_data;
    logic [11:0] ir_reg_bus;
    logic        ir_valid;
    logic        skip_req = 1'b0;
    logic        pcl_we = 1'b0;
    logic [7:0]  pcl_data = 8'h00;
    logic        stack_ovf;

    logic [11:0] mem [0:511];
    assign prog_data = mem[prog_addr];

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int          m_pc, m_depth;
    logic [11:0] m_ir;
    logic        m_val, m_ovf;
    int          m_stk [2];

    pic10_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .prog_addr(prog_addr),
        .prog_data(prog_data), .ir_reg_bus(ir_reg_bus), .ir_valid(ir_valid),
        .skip_req(skip_req), .pcl_we(pcl_we), .pcl_data(pcl_data),
        .stack_ovf(stack_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = 'h1FF; m_ir = 12'h000; m_val = 0; m_ovf = 0;
        m_stk[0] = 0; m_stk[1] = 0; m_depth = 0;
    endtask

    // one clock edge worth of the architectural rules, from the current inputs
    task automatic model_tick();
        logic [11:0] word;
        bit go, call, ret, pw, taken, flush;
        int npc;
        if (stall) return;
        word  = mem[m_pc];
        pw    = m_val && pcl_we;
        go    = m_val && (m_ir >> 9) == 5;
        call  = m_val && (m_ir >> 8) == 9;
        ret   = m_val && (m_ir >> 8) == 8;
        taken = pw || go || call || ret;
        flush = taken || (m_val && skip_req);
        if (pw)        npc = pcl_data;
        else if (go)   npc = m_ir % 512;
        else if (call) begin
            if (m_depth == 2) m_ovf = 1;
            m_stk[1] = m_stk[0];
            m_stk[0] = m_pc;
            m_depth  = (m_depth + 1 > 2) ? 2 : m_depth + 1;
            npc = m_ir % 256;
        end else if (ret) begin
            npc      = m_stk[0];
            m_stk[0] = m_stk[1];
            m_depth  = (m_depth > 0) ? m_depth - 1 : 0;
        end else npc = (m_pc + 1) % 512;
        m_pc  = npc;
        m_ir  = flush ? 12'h000 : word;
        m_val = !flush;
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; skip_req = 0; pcl_we = 0; pcl_data = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 12'h000;
    endtask

    task automatic test_reset_linear();
        logic [8:0]  epc [5];
        logic [11:0] eir [5];
        epc = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004};
        eir = '{12'hC25, 12'h1C0, 12'h1C1, 12'h1C2, 12'h1C3};
        clear_mem();
        mem[9'h1FF] = 12'hC25;
        for (int i = 0; i < 4; i++) mem[i] = 12'h1C0 + 12'(i);
        mem[9'h004] = 12'hAF0;
        mem[9'h0F0] = 12'h3A5;
        do_reset();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid, stack_ovf} !== {9'h1FF, 12'h000, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h ir=%h v=%b ovf=%b want pc=1ff ir=000 v=0 ovf=0",
                     prog_addr, ir_reg_bus, ir_valid, stack_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({prog_addr, ir_reg_bus, ir_valid} !== {epc[i], eir[i], 1'b1}) begin
                n_bad++;
                $display("FAIL linear[%0d]: got pc=%h ir=%h v=%b want pc=%h ir=%h v=1",
                         i, prog_addr, ir_reg_bus, ir_valid, epc[i], eir[i]);
            end
        end
    endtask

    task automatic test_goto();
        step();
        n_cmp++;
        if ({ir_reg_bus, ir_valid} !== {12'hAF0, 1'b1}) begin
            n_bad++;
            $display("FAIL goto_in_ir: got ir=%h v=%b want ir=af0 v=1", ir_reg_bus, ir_valid);
        end
        step();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid} !== {9'h0F0, 12'h000, 1'b0}) begin
            n_bad++;
            $display("FAIL goto_bubble: got pc=%h ir=%h v=%b want pc=0f0 ir=000 v=0",
                     prog_addr, ir_reg_bus, ir_valid);
        end
        step();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid} !== {9'h0F1, 12'h3A5, 1'b1}) begin
            n_bad++;
            $display("FAIL goto_target: got pc=%h ir=%h v=%b want pc=0f1 ir=3a5 v=1",
                     prog_addr, ir_reg_bus, ir_valid);
        end
    endtask

    task automatic test_call_ret();
        clear_mem();
        mem[9'h000] = 12'hA10;
        mem[9'h010] = 12'h940;
        mem[9'h040] = 12'h950;
        mem[9'h050] = 12'h855;
        mem[9'h041] = 12'h866;
        mem[9'h011] = 12'h2B7;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            step();
            n_cmp++;
            if ({prog_addr, ir_reg_bus, ir_valid, stack_ovf} !== {m_pc[8:0], m_ir, m_val, m_ovf}) begin
                n_bad++;
                $display("FAIL call_model[%0d]: got pc=%h ir=%h v=%b ovf=%b want pc=%h ir=%h v=%b ovf=%b",
                         e, prog_addr, ir_reg_bus, ir_valid, stack_ovf, m_pc[8:0], m_ir, m_val, m_ovf);
            end
            if (e == 5 || e == 7 || e == 9 || e == 11) begin
                n_cmp++;
                if (ir_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL call_bubble[%0d]: got v=%b want v=0", e, ir_valid);
                end
            end
        end
        // edge 9 returned to 041, edge 11 to 011, edge 12 fetched from 011
        n_cmp++;
        if ({prog_addr, ir_reg_bus, stack_ovf} !== {9'h012, 12'h2B7, 1'b0}) begin
            n_bad++;
            $display("FAIL call_return: got pc=%h ir=%h ovf=%b want pc=012 ir=2b7 ovf=0",
                     prog_addr, ir_reg_bus, stack_ovf);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] want;
        clear_mem();
        mem[9'h000] = 12'h960;
        mem[9'h060] = 12'h970;
        mem[9'h070] = 12'h980;
        mem[9'h080] = 12'h8AA;
        mem[9'h071] = 12'h8BB;
        mem[9'h061] = 12'h8CC;
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            step();
            want = 9'h000;
            case (e)
                7:  want = 9'h080;
                9:  want = 9'h071;
                11: want = 9'h061;
                13: want = 9'h061;
                default: want = m_pc[8:0];
            endcase
            n_cmp++;
            if ({prog_addr, ir_valid} !== {want, m_val}) begin
                n_bad++;
                $display("FAIL ovf_pc[%0d]: got pc=%h v=%b want pc=%h v=%b",
                         e, prog_addr, ir_valid, want, m_val);
            end
            if (e >= 7) begin
                n_cmp++;
                if (stack_ovf !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ovf_flag[%0d]: got %b want 1", e, stack_ovf);
                end
            end
        end
    endtask

    task automatic test_skip();
        clear_mem();
        mem[9'h000] = 12'hA20;
        mem[9'h020] = 12'h6AB;
        mem[9'h021] = 12'h123;
        mem[9'h022] = 12'h222;
        mem[9'h023] = 12'h333;
        do_reset();
        for (int e = 0; e < 4; e++) step();
        skip_req = 1;
        step();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid} !== {9'h022, 12'h000, 1'b0}) begin
            n_bad++;
            $display("FAIL skip_bubble: got pc=%h ir=%h v=%b want pc=022 ir=000 v=0",
                     prog_addr, ir_reg_bus, ir_valid);
        end
        step();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid} !== {9'h023, 12'h222, 1'b1}) begin
            n_bad++;
            $display("FAIL skip_ignored: got pc=%h ir=%h v=%b want pc=023 ir=222 v=1",
                     prog_addr, ir_reg_bus, ir_valid);
        end
        skip_req = 0;
        step();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid} !== {9'h024, 12'h333, 1'b1}) begin
            n_bad++;
            $display("FAIL skip_resume: got pc=%h ir=%h v=%b want pc=024 ir=333 v=1",
                     prog_addr, ir_reg_bus, ir_valid);
        end
    endtask

    // continues straight from the overflow scenario, so stack_ovf is 1 going in
    task automatic test_stall_reset();
        stall = 1; skip_req = 1; pcl_we = 1; pcl_data = 8'h5A;
        for (int e = 0; e < 3; e++) begin
            step();
            n_cmp++;
            if ({prog_addr, ir_reg_bus, ir_valid} !== {9'h061, 12'h000, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got pc=%h ir=%h v=%b want pc=061 ir=000 v=0",
                         e, prog_addr, ir_reg_bus, ir_valid);
            end
        end
        stall = 0; skip_req = 0; pcl_we = 0;
        step();
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid, stack_ovf} !== {9'h062, 12'h8CC, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_release: got pc=%h ir=%h v=%b ovf=%b want pc=062 ir=8cc v=1 ovf=1",
                     prog_addr, ir_reg_bus, ir_valid, stack_ovf);
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({prog_addr, ir_reg_bus, ir_valid, stack_ovf} !== {9'h1FF, 12'h000, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got pc=%h ir=%h v=%b ovf=%b want pc=1ff ir=000 v=0 ovf=0",
                     prog_addr, ir_reg_bus, ir_valid, stack_ovf);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 512; i++) mem[i] = 12'($urandom);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            stall    = ($urandom_range(0, 4) == 0);
            skip_req = ($urandom_range(0, 3) == 0);
            pcl_we   = ($urandom_range(0, 19) == 0);
            pcl_data = 8'($urandom);
            step();
            n_cmp++;
            if ({prog_addr, ir_reg_bus, ir_valid, stack_ovf} !== {m_pc[8:0], m_ir, m_val, m_ovf}) begin
                n_bad++;
                $display("FAIL random[%0d]: got pc=%h ir=%h v=%b ovf=%b want pc=%h ir=%h v=%b ovf=%b",
                         c, prog_addr, ir_reg_bus, ir_valid, stack_ovf, m_pc[8:0], m_ir, m_val, m_ovf);
            end
        end
        stall = 0; skip_req = 0; pcl_we = 0;
    endtask

    initial begin
        clear_mem();
        model_reset();
        test_reset_linear();
        test_goto();
        test_call_ret();
        test_overflow();
        test_stall_reset();
        test_skip();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
